// File: rtl/inst_mem_loader_if.sv
// Host-side byte stream, instruction RAM write port and CPU stall/status
// signals of the instruction memory loader, bundled as one interface.
interface inst_mem_loader_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              start;
   logic [6:0]        load_len;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   // Host / stream source side
   modport master (
      output start, load_len, byte_in, byte_valid,
      input  byte_ready, we, waddr, wdata, cpu_hold, done, err
   );

   // Loader side
   modport slave (
      input  start, load_len, byte_in, byte_valid,
      output byte_ready, we, waddr, wdata, cpu_hold, done, err
   );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit
// words, writes them to consecutive instruction RAM addresses starting at
// BASE_ADDR and stalls the CPU for the whole load.
// Optional trailing XOR checksum byte: define INST_LOADER_CHKSUM_EN.
module inst_mem_loader #(
   parameter int unsigned       ADDR_W    = 6,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic               clk,
   input logic               rst,
   inst_mem_loader_if.slave  bus
);

`ifdef INST_LOADER_CHKSUM_EN
   typedef enum logic [2:0] {StIdle, StRecv, StWrite, StChk, StDone} state_e;
`else
   typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone} state_e;
`endif

   state_e            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [6:0]        word_cnt_q, word_cnt_d;
   logic [6:0]        len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic [6:0]        eff_len;

   // 0 and anything above 64 both mean a full 64-word load
   assign eff_len = (bus.load_len == 7'd0 || bus.load_len > 7'd64) ? 7'd64 : bus.load_len;

`ifdef INST_LOADER_CHKSUM_EN
   logic [7:0] xor_q, xor_d;
   logic       err_q, err_d;
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         byte_cnt_q <= '0;
         word_cnt_q <= '0;
         len_q      <= '0;
         addr_q     <= BASE_ADDR;
         word_q     <= '0;
`ifdef INST_LOADER_CHKSUM_EN
         xor_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
`ifdef INST_LOADER_CHKSUM_EN
         xor_q      <= xor_d;
         err_q      <= err_d;
`endif
      end
   end

   // Next-state logic and Moore outputs; waddr/wdata are zero outside WRITE
   always_comb begin
      state_d        = state_q;
      byte_cnt_d     = byte_cnt_q;
      word_cnt_d     = word_cnt_q;
      len_d          = len_q;
      addr_d         = addr_q;
      word_d         = word_q;
`ifdef INST_LOADER_CHKSUM_EN
      xor_d          = xor_q;
      err_d          = err_q;
`endif
      bus.byte_ready = 1'b0;
      bus.cpu_hold   = 1'b0;
      bus.we         = 1'b0;
      bus.waddr      = '0;
      bus.wdata      = '0;
      bus.done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               len_d      = eff_len;
               addr_d     = BASE_ADDR;
               byte_cnt_d = '0;
               word_cnt_d = '0;
               word_d     = '0;
`ifdef INST_LOADER_CHKSUM_EN
               xor_d      = '0;
               err_d      = 1'b0;
`endif
               state_d    = StRecv;
            end
         end
         StRecv: begin
            bus.byte_ready = 1'b1;
            bus.cpu_hold   = 1'b1;
            if (bus.byte_valid) begin
               // First byte of a word ends up in bits 31:24
               word_d     = {word_q[23:0], bus.byte_in};
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHKSUM_EN
               xor_d      = xor_q ^ bus.byte_in;
`endif
               if (byte_cnt_q == 2'd3) begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            bus.cpu_hold = 1'b1;
            bus.we       = 1'b1;
            bus.waddr    = addr_q;
            bus.wdata    = word_q;
            addr_d       = addr_q + 1'b1;
            word_cnt_d   = word_cnt_q + 7'd1;
            if (word_cnt_q + 7'd1 == len_q) begin
`ifdef INST_LOADER_CHKSUM_EN
               state_d = StChk;
`else
               state_d = StDone;
`endif
            end else begin
               state_d = StRecv;
            end
         end
`ifdef INST_LOADER_CHKSUM_EN
         StChk: begin
            bus.byte_ready = 1'b1;
            bus.cpu_hold   = 1'b1;
            if (bus.byte_valid) begin
               err_d   = (bus.byte_in != xor_q);
               state_d = StDone;
            end
         end
`endif
         StDone: begin
            bus.cpu_hold = 1'b1;
            bus.done     = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: a cycle-level behavioural model
// derived from byte/word counts checks every output each cycle, plus
// literal expectations from directed loads.
module tb_inst_mem_loader;
   localparam int unsigned AW   = 6;
   localparam logic [5:0]  Base = 6'h3E;
`ifdef INST_LOADER_CHKSUM_EN
   localparam bit Chk = 1'b1;
`else
   localparam bit Chk = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_mem_loader_if #(.ADDR_W(AW)) bus ();

   inst_mem_loader #(.ADDR_W(AW), .BASE_ADDR(Base)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          cyc = 0;
   bit          active = 1'b0;
   int          len, need, acc, words;
   int          last_word_cyc = -10;
   int          done_cyc = -10;
   logic [31:0] sh;
   logic [7:0]  xr;
   logic        exp_err = 1'b0;
   logic [5:0]  pend_addr[$];
   logic [31:0] pend_data[$];

   // Logs used by the directed literal checks
   logic [5:0]  log_addr[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];
   int          last_done_at = -1;

   always @(negedge clk) begin : compare
      bit         e_ready, e_we, e_done;
      logic [5:0] a;
      cyc++;
      if (rst) begin
         active  = 1'b0;
         exp_err = 1'b0;
         pend_addr.delete();
         pend_data.delete();
         check("rst_cpu_hold", bus.cpu_hold, 0);
         check("rst_byte_ready", bus.byte_ready, 0);
         check("rst_we", bus.we, 0);
         check("rst_done", bus.done, 0);
         check("rst_err", bus.err, 0);
         check("rst_waddr", bus.waddr, 0);
         check("rst_wdata", bus.wdata, 0);
      end else begin
         e_ready = active && (acc < need) && (cyc != last_word_cyc + 1);
         e_we    = active && (cyc == last_word_cyc + 1);
         e_done  = active && (cyc == done_cyc);
         check("cpu_hold", bus.cpu_hold, active);
         check("byte_ready", bus.byte_ready, e_ready);
         check("we", bus.we, e_we);
         check("done", bus.done, e_done);
         check("err", bus.err, exp_err);
         if (bus.we) begin
            log_addr.push_back(bus.waddr);
            log_data.push_back(bus.wdata);
            log_cyc.push_back(cyc);
         end
         if (bus.done) last_done_at = cyc;
         if (e_we && pend_addr.size() > 0) begin
            check("waddr", bus.waddr, pend_addr.pop_front());
            check("wdata", bus.wdata, pend_data.pop_front());
         end
         if (active) begin
            if (e_ready && bus.byte_valid) begin
               acc++;
               if (acc <= 4 * len) begin
                  sh = {sh[23:0], bus.byte_in};
                  xr = xr ^ bus.byte_in;
                  if (acc % 4 == 0) begin
                     a = Base + 6'(words);
                     pend_addr.push_back(a);
                     pend_data.push_back(sh);
                     words++;
                     last_word_cyc = cyc;
                     if (acc == 4 * len && !Chk) done_cyc = cyc + 2;
                  end
               end else begin
                  exp_err  = (bus.byte_in != xr);
                  done_cyc = cyc + 1;
               end
            end
            if (cyc == done_cyc) active = 1'b0;
         end else if (bus.start) begin
            active        = 1'b1;
            len           = (bus.load_len == 0 || bus.load_len > 64) ? 64 : int'(bus.load_len);
            need          = 4 * len + (Chk ? 1 : 0);
            acc           = 0;
            words         = 0;
            sh            = '0;
            xr            = '0;
            exp_err       = 1'b0;
            last_word_cyc = -10;
            done_cyc      = -10;
            pend_addr.delete();
            pend_data.delete();
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic start_load(input int l);
      bus.load_len = 7'(l);
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      bus.byte_valid = 1'b0;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.byte_ready && n < 300);
      check("byte_taken", bus.byte_ready, 1);
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic stream(input logic [7:0] q[$], input int gap_lo, input int gap_hi,
                         input bit busy);
      for (int i = 0; i < q.size(); i++) begin
         if (busy && i > 0 && (i == 1 || $urandom % 8 == 0)) begin
            bus.load_len = 7'($urandom_range(127, 0));
            bus.start    = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
         end
         send_byte(q[i], $urandom_range(gap_hi, gap_lo));
      end
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 2000);
      check("done_seen", bus.done, 1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
      logic [7:0] x = '0;
      foreach (q[i]) x ^= q[i];
      return x;
   endfunction

   task automatic basic_literals(input string tag);
      check({tag, "_nwrites"}, log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         check({tag, "_addr0"}, log_addr[0], 6'h3E);
         check({tag, "_data0"}, log_data[0], 32'h3800_0866);
         check({tag, "_addr1"}, log_addr[1], 6'h3F);
         check({tag, "_data1"}, log_data[1], 32'h3400_0481);
         check({tag, "_done_lat"}, last_done_at, log_cyc[1] + 1);
      end
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin : main
      logic [7:0] basic[$];
      logic [7:0] q[$];
      int         l, nw, r;

      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.load_len   = '0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      basic = '{8'h38, 8'h00, 8'h08, 8'h66, 8'h34, 8'h00, 8'h04, 8'h81};
      if (Chk) basic.push_back(xor_of(basic));

      // Basic back-to-back load
      clear_log();
      start_load(2);
      stream(basic, 0, 0, 1'b0);
      wait_done();
      basic_literals("basic");

      // Throttled source
      clear_log();
      start_load(2);
      stream(basic, 3, 3, 1'b0);
      wait_done();
      basic_literals("throttled");

      // Start pulses while busy are ignored
      clear_log();
      start_load(2);
      stream(basic, 0, 1, 1'b1);
      wait_done();
      basic_literals("busy");

      // Full 64-word load wrapping the address
      clear_log();
      q.delete();
      for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
      if (Chk) q.push_back(xor_of(q));
      start_load(0);
      stream(q, 0, 0, 1'b0);
      wait_done();
      check("wrap_nwrites", log_addr.size(), 64);
      if (log_addr.size() == 64) begin
         check("wrap_addr0", log_addr[0], 6'h3E);
         check("wrap_addr1", log_addr[1], 6'h3F);
         check("wrap_addr2", log_addr[2], 6'h00);
         check("wrap_addr63", log_addr[63], 6'h3D);
         check("wrap_data2", log_data[2], {q[8], q[9], q[10], q[11]});
      end

      // Reset in the middle of a 4-word load
      start_load(4);
      for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
      rst = 1'b1;
      #1;
      check("midrst_cpu_hold", bus.cpu_hold, 0);
      check("midrst_byte_ready", bus.byte_ready, 0);
      check("midrst_we", bus.we, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_log();
      q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      if (Chk) q.push_back(xor_of(q));
      start_load(1);
      stream(q, 0, 0, 1'b0);
      wait_done();
      check("postrst_nwrites", log_addr.size(), 1);
      if (log_addr.size() == 1) begin
         check("postrst_addr", log_addr[0], 6'h3E);
         check("postrst_data", log_data[0], 32'hDEAD_BEEF);
      end

`ifdef INST_LOADER_CHKSUM_EN
      // Checksum good and bad trailer
      clear_log();
      q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
      start_load(1);
      stream(q, 0, 0, 1'b0);
      wait_done();
      check("chk_good_err", bus.err, 0);
      if (log_data.size() == 1) check("chk_good_data", log_data[0], 32'h1234_5678);
      else check("chk_good_nwrites", log_data.size(), 1);
      clear_log();
      q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      start_load(1);
      stream(q, 0, 0, 1'b0);
      wait_done();
      check("chk_bad_err", bus.err, 1);
      if (log_data.size() == 1) check("chk_bad_data", log_data[0], 32'h1234_5678);
      else check("chk_bad_nwrites", log_data.size(), 1);
`endif

      // Randomised loads
      for (int k = 0; k < 14; k++) begin
         r = int'($urandom % 10);
         if (r < 7)       l = int'($urandom_range(4, 1));
         else if (r == 7) l = (k < 7) ? 0 : 3;
         else if (r == 8) l = (k < 7) ? int'($urandom_range(127, 65)) : 5;
         else             l = int'($urandom_range(8, 1));
         nw = (l == 0 || l > 64) ? 64 : l;
         q.delete();
         for (int i = 0; i < 4 * nw; i++) q.push_back(8'($urandom));
         if (Chk) q.push_back(xor_of(q) ^ 8'($urandom % 2));
         clear_log();
         start_load(l);
         stream(q, 0, 2, ($urandom % 2) == 1);
         wait_done();
         check("rand_nwrites", log_addr.size(), nw);
         repeat ($urandom_range(3, 0)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side companion to the CPU's 64 x 32-bit instruction memory.
- Accepts a byte stream from a host link (UART RX or debug port) and packs each group of 4 bytes into one instruction word, big-endian.
- Writes consecutive words into the writable instruction RAM and holds the pipeline CPU in stall until loading completes.

Parameters:
- ADDR_W, 6, instruction memory address width (64 words).
- BASE_ADDR, 6'h00, first word address written by each load.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- load_len  in  7  number of words to load; 0 means 64; values above 64 are clamped to 64; sampled when start is accepted.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- we  out  1  instruction RAM write enable, one-cycle pulse per word.
- waddr  out  ADDR_W  instruction RAM write address.
- wdata  out  32  instruction RAM write data.
- cpu_hold  out  1  stalls the CPU and holds its PC while loading.
- done  out  1  one-cycle pulse when a load finishes.
- err  out  1  checksum error flag (tied 0 without the optional feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; word counter 0; address register = BASE_ADDR; shift register 0. Reset mid-load aborts immediately: cpu_hold drops, and words already written stay in RAM.
- States: IDLE, RECV, WRITE, (CHK), DONE.
- IDLE:
  - byte_ready=0, cpu_hold=0.
  - When start=1, latch load_len, set address to BASE_ADDR, clear counters → RECV.
- RECV:
  - byte_ready=1, cpu_hold=1.
  - A byte transfers on a rising edge where byte_valid && byte_ready. Shift-in: word = {word[23:0], byte_in}, so the first byte lands in bits 31:24.
  - byte_valid may drop for any number of cycles; there is no timeout.
  - After the 4th byte → WRITE.
- WRITE:
  - byte_ready=0, cpu_hold=1. Exactly one cycle: we=1, waddr=address register, wdata=assembled word.
  - Next edge: address += 1 (wraps modulo 2^ADDR_W), word count += 1.
  - If word count reaches the latched length → DONE (or CHK when the feature is enabled); else → RECV.
- DONE:
  - done=1 for one cycle with cpu_hold still 1, then → IDLE, where cpu_hold=0.
- Latency:
  - 4th accepted byte → we high on the next cycle.
  - Last we → done on the next cycle.
  - Minimum 5 cycles per word.
- start while not in IDLE is ignored.
- A byte presented while byte_ready=0 is not consumed. The source must hold it.
- Length 64 with BASE_ADDR≠0 wraps the address through 63→0 and overwrites from the start of the range.
- err is cleared when start is accepted and held until the next start or reset.

Optional Feature:
- Macro: INST_LOADER_CHKSUM_EN.
- Enabled:
  - A running XOR of all data bytes is kept.
  - After the last WRITE, the FSM enters CHK with byte_ready=1 and accepts one more byte.
  - If that byte ≠ running XOR, err=1.
  - → DONE either way. Writes are never undone.
- Disabled: no CHK state, no XOR logic; err tied to 0; WRITE goes directly to DONE.

Test Plan:
- Basic load: load_len=2, stream 38 00 08 66 34 00 04 81 back-to-back → we at waddr 0 with 0x38000866, then waddr 1 with 0x34000481. done pulses 1 cycle after the 2nd we. cpu_hold high from the cycle after start through the done cycle.
- Throttled source: same stream with byte_valid low 3 cycles between bytes → identical writes. byte_ready is never low in RECV, and no byte is dropped or duplicated.
- Full range with wrap: BASE_ADDR=6'h3E, load_len=0, 256 bytes → 64 writes at addresses 3E, 3F, 00 … 3D. Exactly 64 we pulses.
- Reset mid-load: assert rst after 6 bytes of a 4-word load → all outputs 0 immediately. A subsequent start with load_len=1 writes waddr=BASE_ADDR correctly.
- Busy start: pulse start during RECV → ignored; the load in progress completes unchanged.
- Checksum (with INST_LOADER_CHKSUM_EN): bytes 12 34 56 78 then 08 → err=0. Repeat with trailing 09 → err=1. In both cases the word 0x12345678 is written.
